// File: rtl/npu_chk_pkg.sv
// Shared definitions for the output-memory checker: FSM state encoding and
// the deepest memory read latency the alignment pipe is expected to cover.
package npu_chk_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/chk_valid_pipe.sv
// Valid/index delay line: carries each issued read index forward so it
// emerges in the same cycle as the matching memory read data.
module chk_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  // Flush drops every in-flight entry so an aborted check cannot leak results
  // into the next one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/out_mem_checker.sv
// Compares a DUT output memory against a golden memory word by word under a
// bit mask, reporting a mismatch count and details of the first mismatch.
module out_mem_checker
  import npu_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] dut_base,
  input  logic [ADDR_W-1:0] gold_base,
  input  logic              stop_on_fail,
  input  logic [DATA_W-1:0] cmp_mask,
  output logic              dut_en,
  output logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_dout,
  output logic              gold_en,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [DATA_W-1:0] gold_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_dut,
  output logic [DATA_W-1:0] first_err_gold
);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, dbase_q, gbase_q;
  logic              stop_q;
  logic [DATA_W-1:0] mask_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] ferr_idx_q, ferr_idx_d;
  logic [DATA_W-1:0] ferr_dut_q, ferr_dut_d;
  logic [DATA_W-1:0] ferr_gold_q, ferr_gold_d;

  logic              accept;
  logic              issue;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_idx;
  logic              cmp_valid;
  logic              mismatch;
  logic [ADDR_W-1:0] last_idx;

  assign accept    = (state_q == ST_IDLE) && start;
  assign issue     = (state_q == ST_ISSUE);
  assign last_idx  = len_q - 1'b1;
  assign cmp_valid = pipe_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign mismatch  = cmp_valid && (|((dut_dout ^ gold_dout) & mask_q));

  chk_valid_pipe #(
    .DEPTH (RD_LAT),
    .IDX_W (ADDR_W)
  ) u_pipe (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i ((state_q == ST_DONE) || (state_q == ST_IDLE)),
    .valid_i (issue),
    .idx_i   (idx_q),
    .valid_o (pipe_valid),
    .idx_o   (pipe_idx)
  );

  // Next state, issue index and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    pass_d      = pass_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_dut_d  = ferr_dut_q;
    ferr_gold_d = ferr_gold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = (len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == last_idx) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cmp_valid && (pipe_idx == last_idx)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // An early stop overrides normal sequencing; later in-flight reads are flushed.
    if (stop_q && mismatch) state_d = ST_DONE;

    if (accept) begin
      err_cnt_d   = '0;
      pass_d      = 1'b0;
      ferr_idx_d  = '0;
      ferr_dut_d  = '0;
      ferr_gold_d = '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) begin
        ferr_idx_d  = pipe_idx;
        ferr_dut_d  = dut_dout;
        ferr_gold_d = gold_dout;
      end
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) pass_d = (err_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      pass_q      <= 1'b0;
      ferr_idx_q  <= '0;
      ferr_dut_q  <= '0;
      ferr_gold_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      pass_q      <= pass_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_dut_q  <= ferr_dut_d;
      ferr_gold_q <= ferr_gold_d;
    end
  end

  // Check configuration is frozen at start so input changes mid-run are harmless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q   <= '0;
      dbase_q <= '0;
      gbase_q <= '0;
      stop_q  <= 1'b0;
      mask_q  <= '0;
    end else if (accept) begin
      len_q   <= len;
      dbase_q <= dut_base;
      gbase_q <= gold_base;
      stop_q  <= stop_on_fail;
      mask_q  <= cmp_mask;
    end
  end

  assign dut_en         = issue;
  assign gold_en        = issue;
  assign dut_addr       = dbase_q + idx_q;
  assign gold_addr      = gbase_q + idx_q;
  assign busy           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = ferr_idx_q;
  assign first_err_dut  = ferr_dut_q;
  assign first_err_gold = ferr_gold_q;

endmodule

// File: tb/tb_out_mem_checker.sv
// Directed and randomized checks of out_mem_checker against a word-level
// reference model computed from the memory contents.
module tb_out_mem_checker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] len, dut_base, gold_base;
  logic              stop_on_fail;
  logic [DATA_W-1:0] cmp_mask;
  logic              dut_en, gold_en;
  logic [ADDR_W-1:0] dut_addr, gold_addr;
  logic [DATA_W-1:0] dut_dout, gold_dout;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err_idx;
  logic [DATA_W-1:0] first_err_dut, first_err_gold;

  logic [DATA_W-1:0] dutMem  [65536];
  logic [DATA_W-1:0] goldMem [65536];
  logic [DATA_W-1:0] dutPipe  [RD_LAT];
  logic [DATA_W-1:0] goldPipe [RD_LAT];

  int total = 0;
  int bad   = 0;

  out_mem_checker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .len            (len),
    .dut_base       (dut_base),
    .gold_base      (gold_base),
    .stop_on_fail   (stop_on_fail),
    .cmp_mask       (cmp_mask),
    .dut_en         (dut_en),
    .dut_addr       (dut_addr),
    .dut_dout       (dut_dout),
    .gold_en        (gold_en),
    .gold_addr      (gold_addr),
    .gold_dout      (gold_dout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_idx  (first_err_idx),
    .first_err_dut  (first_err_dut),
    .first_err_gold (first_err_gold)
  );

  always #5 clk = ~clk;

  // Memories with RD_LAT cycles of read latency.
  always @(posedge clk) begin
    dutPipe[0]  <= dut_en  ? dutMem[dut_addr]   : '0;
    goldPipe[0] <= gold_en ? goldMem[gold_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      dutPipe[i]  <= dutPipe[i-1];
      goldPipe[i] <= goldPipe[i-1];
    end
  end
  assign dut_dout  = dutPipe[RD_LAT-1];
  assign gold_dout = goldPipe[RD_LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Fill n consecutive words of both memories with identical random data.
  task automatic fillPair(input logic [ADDR_W-1:0] db, input logic [ADDR_W-1:0] gb, input int n);
    logic [ADDR_W-1:0] a, g;
    for (int i = 0; i < n; i++) begin
      a = db + ADDR_W'(i);
      g = gb + ADDR_W'(i);
      dutMem[a]  = $urandom;
      goldMem[g] = dutMem[a];
    end
  endtask

  // Run one check and compare against the word-level reference model.
  task automatic applyStimulus(input string name, input int n, input logic [ADDR_W-1:0] db,
                               input logic [ADDR_W-1:0] gb, input bit stp,
                               input logic [DATA_W-1:0] msk, input bit poke);
    int count, first, expErr, expIssued, expDone, expFirst;
    logic [DATA_W-1:0] expFd, expFg, d, g;
    int nDut, nGold, addrErrs, busyErrs, doneCnt, doneCyc;
    logic [CNT_W-1:0]  gotErr;
    logic              gotPass, gotBusy;
    logic [ADDR_W-1:0] gotIdx;
    logic [DATA_W-1:0] gotFd, gotFg;

    count = 0; first = -1; expFd = '0; expFg = '0;
    for (int i = 0; i < n; i++) begin
      d = dutMem[db + ADDR_W'(i)];
      g = goldMem[gb + ADDR_W'(i)];
      if (((d ^ g) & msk) != 0) begin
        if (first < 0) begin
          first = i; expFd = d; expFg = g;
        end
        count++;
      end
    end
    if (stp && first >= 0) begin
      expErr    = 1;
      expIssued = (first + RD_LAT + 1 < n) ? first + RD_LAT + 1 : n;
      expDone   = first + RD_LAT + 2;
    end else begin
      expErr    = (count > 65535) ? 65535 : count;
      expIssued = n;
      expDone   = (n == 0) ? 1 : n + RD_LAT + 1;
    end
    expFirst = (first < 0) ? 0 : first;

    nDut = 0; nGold = 0; addrErrs = 0; busyErrs = 0; doneCnt = 0; doneCyc = 0;
    gotErr = '0; gotPass = 1'b0; gotBusy = 1'b1; gotIdx = '0; gotFd = '0; gotFg = '0;

    @(negedge clk);
    start = 1'b1; len = ADDR_W'(n); dut_base = db; gold_base = gb;
    stop_on_fail = stp; cmp_mask = msk;
    @(posedge clk);
    for (int k = 1; k <= n + RD_LAT + 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke && k == 3) begin
        start = 1'b1; len = '0; dut_base = 16'h1234; stop_on_fail = ~stp;
      end
      if (poke && k == 4) start = 1'b0;
      if (dut_en === 1'b1) begin
        if (dut_addr !== db + ADDR_W'(nDut)) addrErrs++;
        nDut++;
      end
      if (gold_en === 1'b1) begin
        if (gold_addr !== gb + ADDR_W'(nGold)) addrErrs++;
        nGold++;
      end
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc == 0) begin
          doneCyc = k; gotErr = err_cnt; gotPass = pass; gotBusy = busy;
          gotIdx = first_err_idx; gotFd = first_err_dut; gotFg = first_err_gold;
        end
      end else if (doneCyc == 0 && busy !== 1'b1) begin
        busyErrs++;
      end
      if (doneCyc != 0 && k >= doneCyc + 4) break;
    end

    checkOutput({name, ".done_cycle"}, 64'(doneCyc), 64'(expDone));
    checkOutput({name, ".done_pulses"}, 64'(doneCnt), 64'd1);
    checkOutput({name, ".dut_issued"}, 64'(nDut), 64'(expIssued));
    checkOutput({name, ".gold_issued"}, 64'(nGold), 64'(expIssued));
    checkOutput({name, ".addr_errs"}, 64'(addrErrs), 64'd0);
    checkOutput({name, ".busy_errs"}, 64'(busyErrs), 64'd0);
    checkOutput({name, ".busy_at_done"}, 64'(gotBusy), 64'd0);
    checkOutput({name, ".err_cnt"}, 64'(gotErr), 64'(expErr));
    checkOutput({name, ".pass"}, 64'(gotPass), 64'(expErr == 0));
    checkOutput({name, ".first_idx"}, 64'(gotIdx), 64'(expFirst));
    checkOutput({name, ".first_dut"}, 64'(gotFd), 64'(expFd));
    checkOutput({name, ".first_gold"}, 64'(gotFg), 64'(expFg));
    checkOutput({name, ".err_cnt_hold"}, 64'(err_cnt), 64'(expErr));
    checkOutput({name, ".pass_hold"}, 64'(pass), 64'(expErr == 0));
  endtask

  // Abort a long check with reset at index 300 and confirm a clean restart.
  task automatic resetMidRun();
    logic [ADDR_W-1:0] db, gb;
    bit reached;
    int doneSeen;
    db = 16'h3000; gb = 16'h7000;
    fillPair(db, gb, 1000);
    dutMem[db + 16'd5]   = ~goldMem[gb + 16'd5];
    dutMem[db + 16'd100] = ~goldMem[gb + 16'd100];
    @(negedge clk);
    start = 1'b1; len = 16'd1000; dut_base = db; gold_base = gb;
    stop_on_fail = 1'b0; cmp_mask = '1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (dut_en === 1'b1 && dut_addr === db + 16'd300) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rst.reach_idx300", 64'(reached), 64'd1);
    checkOutput("rst.err_before", 64'(err_cnt), 64'd2);
    resetn = 1'b0;
    #1;
    checkOutput("rst.dut_en", 64'(dut_en), 64'd0);
    checkOutput("rst.gold_en", 64'(gold_en), 64'd0);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("rst.pass", 64'(pass), 64'd0);
    checkOutput("rst.first_idx", 64'(first_err_idx), 64'd0);
    doneSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done !== 1'b0) doneSeen++;
    end
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
    end
    checkOutput("rst.no_done", 64'(doneSeen), 64'd0);
    applyStimulus("rst.len0", 0, 16'h0000, 16'h0000, 1'b0, '1, 1'b0);
  endtask

  initial begin
    logic [ADDR_W-1:0] db, gb;
    logic [DATA_W-1:0] msk;
    int n, nInj;
    bit stp;

    resetn = 1'b0; start = 1'b0; len = '0; dut_base = '0; gold_base = '0;
    stop_on_fail = 1'b0; cmp_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.dut_en", 64'(dut_en), 64'd0);
    checkOutput("reset.gold_en", 64'(gold_en), 64'd0);
    checkOutput("reset.dut_addr", 64'(dut_addr), 64'd0);
    checkOutput("reset.pass", 64'(pass), 64'd0);
    checkOutput("reset.err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("reset.first_err", 64'({first_err_idx, first_err_dut}), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    fillPair(16'h0100, 16'h2000, 1000);
    applyStimulus("match1000", 1000, 16'h0100, 16'h2000, 1'b0, '1, 1'b1);

    dutMem[16'h0100 + 16'd537]  = 32'hDEADBEEF;
    goldMem[16'h2000 + 16'd537] = 32'hDEADBEEE;
    applyStimulus("inject537", 1000, 16'h0100, 16'h2000, 1'b0, '1, 1'b0);
    applyStimulus("masked537", 1000, 16'h0100, 16'h2000, 1'b0, 32'hFFFF_FFFE, 1'b0);

    fillPair(16'h0400, 16'h0800, 1000);
    dutMem[16'h0400 + 16'd10] = dutMem[16'h0400 + 16'd10] ^ 32'h0000_0008;
    dutMem[16'h0400 + 16'd20] = dutMem[16'h0400 + 16'd20] ^ 32'h0100_0000;
    applyStimulus("stop10", 1000, 16'h0400, 16'h0800, 1'b1, '1, 1'b0);

    fillPair(16'hFFFE, 16'h0010, 4);
    applyStimulus("wrap", 4, 16'hFFFE, 16'h0010, 1'b0, '1, 1'b0);

    applyStimulus("len0", 0, 16'h0055, 16'h0066, 1'b0, '1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(1, 300);
      db   = ADDR_W'($urandom);
      gb   = ADDR_W'($urandom);
      stp  = 1'($urandom_range(0, 1));
      msk  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      nInj = $urandom_range(0, 3);
      fillPair(db, gb, n);
      for (int j = 0; j < nInj; j++) begin
        int p;
        p = $urandom_range(0, n - 1);
        dutMem[db + ADDR_W'(p)] = dutMem[db + ADDR_W'(p)] ^ (32'h1 << $urandom_range(0, 31));
      end
      applyStimulus($sformatf("rand%0d", r), n, db, gb, stp, msk, 1'b0);
    end

    resetMidRun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
